// File: rtl/oisc_ibus_core.sv
// Transport bus of the 8-bit OISC: resolves the driver slots into one bus word,
// decodes src/dst into one-hot select/strobe lines and tracks contention.
module oisc_ibus_core #(
  parameter int DWIDTH  = 8,
  parameter int SAWIDTH = 7,
  parameter int DAWIDTH = 5,
  parameter int NDRV    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SAWIDTH-1:0]      instr_src,
  input  logic [DAWIDTH-1:0]      instr_dst,
  input  logic                    imm,
  input  logic [NDRV*DWIDTH-1:0]  drv_data,
  input  logic [NDRV-1:0]         drv_en,
  output logic [DWIDTH-1:0]       data,
  output logic [2**SAWIDTH-1:0]   rd_sel,
  output logic [2**DAWIDTH-1:0]   wr_stb,
  output logic                    contention,
  output logic                    floating,
  output logic                    err_sticky,
  output logic [DWIDTH-1:0]       data_q
);

  logic [DWIDTH-1:0] data_p1;
  logic              err_p1;

  // Wired-OR of enabled slots: equals the sole driver's word when exactly one
  // is enabled, zero when none, and a deterministic OR under contention.
  function automatic logic [DWIDTH-1:0] resolve_bus(
    input logic [NDRV*DWIDTH-1:0] words,
    input logic [NDRV-1:0]        en
  );
    logic [DWIDTH-1:0] acc;
    acc = '0;
    for (int k = 0; k < NDRV; k++) begin
      if (en[k]) acc = acc | words[k*DWIDTH +: DWIDTH];
    end
    return acc;
  endfunction

  function automatic logic multi_driver(input logic [NDRV-1:0] en);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int k = 0; k < NDRV; k++) begin
      multi = multi | (seen & en[k]);
      seen  = seen | en[k];
    end
    return multi;
  endfunction

  // Stage p0: combinational bus resolution and address decode
  always_comb begin
    data       = resolve_bus(drv_data, drv_en);
    contention = multi_driver(drv_en);
    floating   = ~|drv_en;
    rd_sel     = '0;
    wr_stb     = '0;
    if (!imm) rd_sel[instr_src] = 1'b1;
    if (!rst) wr_stb[instr_dst] = 1'b1;
  end

  // Stage p1: sampled bus word and sticky contention flag
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
      err_p1  <= 1'b0;
    end else begin
      data_p1 <= data;
      err_p1  <= err_p1 | contention;
    end
  end

  assign data_q     = data_p1;
  assign err_sticky = err_p1;

endmodule

// File: tb/tb_oisc_ibus_core.sv
// Directed bench for oisc_ibus_core with hand-computed expectations.
module tb_oisc_ibus_core;

  localparam int DWIDTH  = 8;
  localparam int SAWIDTH = 7;
  localparam int DAWIDTH = 5;
  localparam int NDRV    = 4;

  logic                   clk;
  logic                   rst;
  logic [SAWIDTH-1:0]     instr_src;
  logic [DAWIDTH-1:0]     instr_dst;
  logic                   imm;
  logic [NDRV*DWIDTH-1:0] drv_data;
  logic [NDRV-1:0]        drv_en;
  logic [DWIDTH-1:0]      data;
  logic [2**SAWIDTH-1:0]  rd_sel;
  logic [2**DAWIDTH-1:0]  wr_stb;
  logic                   contention;
  logic                   floating;
  logic                   err_sticky;
  logic [DWIDTH-1:0]      data_q;

  int n_chk;
  int n_bad;

  oisc_ibus_core #(
    .DWIDTH(DWIDTH), .SAWIDTH(SAWIDTH), .DAWIDTH(DAWIDTH), .NDRV(NDRV)
  ) dut (
    .clk(clk), .rst(rst), .instr_src(instr_src), .instr_dst(instr_dst),
    .imm(imm), .drv_data(drv_data), .drv_en(drv_en), .data(data),
    .rd_sel(rd_sel), .wr_stb(wr_stb), .contention(contention),
    .floating(floating), .err_sticky(err_sticky), .data_q(data_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst = 1'b1; instr_src = '0; instr_dst = 5'd3; imm = 1'b0;
    drv_data = '0; drv_en = '0;

    step();
    step();
    chk("rst_wr_stb", wr_stb, 128'd0);
    chk("rst_data_q", data_q, 128'd0);
    chk("rst_err", err_sticky, 128'd0);
    chk("rst_floating", floating, 128'd1);

    // single driver on slot 1
    rst = 1'b0;
    drv_data = {8'h00, 8'h00, 8'hA5, 8'h00}; drv_en = 4'b0010;
    instr_dst = 5'd5; instr_src = 7'd9;
    #1;
    chk("single_data", data, 128'hA5);
    chk("single_wr_stb", wr_stb, 128'd1 << 5);
    chk("single_rd_sel", rd_sel, 128'd1 << 9);
    chk("single_cont", contention, 128'd0);
    chk("single_float", floating, 128'd0);
    step();
    chk("single_data_q", data_q, 128'hA5);
    chk("single_err", err_sticky, 128'd0);

    // immediate move
    imm = 1'b1; instr_src = 7'd7;
    drv_data = {8'h00, 8'h00, 8'h3C, 8'h00}; drv_en = 4'b0010;
    #1;
    chk("imm_rd_sel", rd_sel, 128'd0);
    chk("imm_data", data, 128'h3C);
    step();
    chk("imm_data_q", data_q, 128'h3C);

    // floating bus
    imm = 1'b0; drv_en = 4'b0000;
    #1;
    chk("float_data", data, 128'd0);
    chk("float_flag", floating, 128'd1);
    chk("float_cont", contention, 128'd0);
    step();
    chk("float_err", err_sticky, 128'd0);
    chk("float_data_q", data_q, 128'd0);

    // two-driver contention
    drv_data = {8'h00, 8'h00, 8'hF0, 8'h0F}; drv_en = 4'b0011;
    #1;
    chk("cont_data", data, 128'hFF);
    chk("cont_flag", contention, 128'd1);
    chk("cont_float", floating, 128'd0);
    chk("cont_err_pre", err_sticky, 128'd0);
    step();
    chk("cont_err_post", err_sticky, 128'd1);
    chk("cont_data_q", data_q, 128'hFF);

    // three-driver contention, OR of enabled slots only
    drv_data = {8'h04, 8'h02, 8'h01, 8'h80}; drv_en = 4'b1110;
    #1;
    chk("cont3_data", data, 128'h07);
    chk("cont3_flag", contention, 128'd1);

    // sticky flag holds after contention clears
    drv_en = 4'b0001;
    #1;
    chk("clear_cont", contention, 128'd0);
    chk("clear_data", data, 128'h80);
    step();
    chk("sticky_hold", err_sticky, 128'd1);
    chk("sticky_data_q", data_q, 128'h80);

    // mid-operation reset: strobes drop immediately, state clears at edge
    rst = 1'b1; instr_dst = 5'd12;
    #1;
    chk("midrst_wr_stb", wr_stb, 128'd0);
    chk("midrst_data", data, 128'h80);
    step();
    chk("midrst_err", err_sticky, 128'd0);
    chk("midrst_data_q", data_q, 128'd0);
    rst = 1'b0;

    // address boundaries
    instr_src = 7'd0; instr_dst = 5'd0;
    #1;
    chk("src0", rd_sel, 128'd1);
    chk("dst0", wr_stb, 128'd1);
    instr_src = 7'd127; instr_dst = 5'd31;
    #1;
    chk("src127", rd_sel, 128'd1 << 127);
    chk("dst31", wr_stb, 128'd1 << 31);
    step();
    chk("end_err", err_sticky, 128'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
